l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single L2 port between the L1 instruction-cache controller and the L1 data-cache controller.
- Samples level requests, grants one requester at a time with round-robin tie-break, and forwards that requester's read/write strobe, line address and write data to L2.
- Returns L2's ready pulse only to the owning requester.
- Sits between both L1 controllers and L2 on the memory-side bus.

Parameters:
ADDR_W, 26, line address width (tag 20 + index 6)
LINE_W, 128, cache line data width

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
read_I_L2  input  1  I-cache line-fill request (level, held until ready_L2_I)
addr_I  input  ADDR_W  I-cache line address
ready_L2_I  output  1  one-cycle completion pulse to I-cache
read_D_L2  input  1  D-cache line-fill request (level)
write_D_L2  input  1  D-cache write-back request (level)
addr_D  input  ADDR_W  D-cache line address
wdata_D  input  LINE_W  D-cache write-back data
ready_L2_D  output  1  one-cycle completion pulse to D-cache
read_arb_L2  output  1  read strobe to L2, held until ready_L2_arb
write_arb_L2  output  1  write strobe to L2, held until ready_L2_arb
addr_arb_L2  output  ADDR_W  address to L2
wdata_arb_L2  output  LINE_W  write data to L2
ready_L2_arb  input  1  L2 completion pulse
owner  output  2  one-hot current owner {D,I}; 00 when idle

Behaviour:
- One clock domain: clk. Reset nrst is asynchronous and active-low.
- Reset values: all outputs 0, state S_IDLE, last_grant=1 (D), so the first tie goes to I.
- State machine:
  - S_IDLE: choose a winner from this cycle's requests.
    - Only one side requesting: that side wins.
    - Both requesting: the side with last_grant != side wins.
    - On a win: register addr/wdata/strobe, set owner and last_grant, go to S_GRANT.
    - No request: stay in S_IDLE.
  - S_GRANT: strobe, addr, wdata and owner are held constant.
    - On ready_L2_arb=1: next cycle strobes clear, ready_L2_<owner> pulses high for exactly one cycle, state goes to S_RELEASE.
  - S_RELEASE: one cycle; owner clears to 00; go to S_IDLE. This lets the requester drop its level request before re-arbitration.
- Latency: request visible at edge t → L2 strobe high after edge t (cycle t+1). ready_L2_arb at cycle k → requester ready at cycle k+1. Earliest re-grant is at cycle k+3.
- D with both read_D_L2 and write_D_L2 asserted: write is issued (write-back precedes allocate). The read remains pending and is arbitrated again after S_RELEASE.
- Request deasserted during S_GRANT: ignored; the transaction completes and ready still pulses to the owner.
- ready_L2_arb in S_IDLE or S_RELEASE: ignored; no ready output is generated.
- Input changes to addr/wdata during S_GRANT have no effect (captured values are held).
- Exactly one of read_arb_L2/write_arb_L2 is high, and only in S_GRANT.
- Reset mid-transaction: immediate return to the reset values; the outstanding L2 access is abandoned.

Optional Feature:
- Macro: L2_ARB_PERF_CNT_EN.
- Defined:
  - Adds 32-bit outputs grant_cnt_I, grant_cnt_D and wait_cnt.
  - grant_cnt_I / grant_cnt_D increment on each S_IDLE→S_GRANT for that side.
  - wait_cnt increments every cycle a requester is asserting a request but is not owner, saturating at 2^32-1.
  - All three reset to 0.
- Undefined: no counters, no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package l2_arb_pkg:
  - state encodings S_IDLE=2'b00, S_GRANT=2'b01, S_RELEASE=2'b10.
  - owner encodings OWN_NONE=2'b00, OWN_I=2'b01, OWN_D=2'b10.
  - default ADDR_W and LINE_W constants.
- One natural sub-module: l2_arb_rr_pick. It is a combinational 2-way round-robin picker: inputs req[1:0] and last_grant; outputs grant one-hot and valid.

Test Plan:
- I-only read, addr_I=26'h0000ABC, L2 ready 3 cycles after the strobe → read_arb_L2=1 with addr 0000ABC; ready_L2_I single pulse the cycle after ready; ready_L2_D never asserted; owner 01→00.
- I and D reads asserted in the same cycle after reset → I granted first; D granted at the earliest re-grant cycle; second tie → I (alternation holds over 4 back-to-back rounds: I,D,I,D).
- D read+write simultaneous, wdata_D=128'hDEAD…BEEF → write_arb_L2 first with that data; after ready, read_arb_L2 issued for same addr_D; two ready_L2_D pulses total.
- Requester drops read_I_L2 mid-S_GRANT and changes addr_I → addr_arb_L2 unchanged; ready_L2_I still pulses once.
- Spurious ready_L2_arb in S_IDLE → no ready outputs; nrst asserted during S_GRANT → strobes, owner and ready outputs all 0 immediately.
- With L2_ARB_PERF_CNT_EN, run the alternation test (4 rounds) → grant_cnt_I=2, grant_cnt_D=2, and wait_cnt equals the summed losing-side wait cycles.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared encodings and default widths for the L2 port arbiter.
package l2_arb_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int LINE_W_DEF = 128;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANT   = 2'b01,
    S_RELEASE = 2'b10
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

endpackage

// File: rtl/l2_arb_rr_pick.sv
// Combinational 2-way round-robin picker; bit 0 is the I-cache, bit 1 the D-cache.
module l2_arb_rr_pick
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  // last_grant=1 means D won last time, so a tie now goes to I.
  always_comb begin
    grant = OWN_NONE;
    unique case (req)
      2'b01:   grant = OWN_I;
      2'b10:   grant = OWN_D;
      2'b11:   grant = last_grant ? OWN_I : OWN_D;
      default: grant = OWN_NONE;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 port between the I- and D-cache controllers (round-robin, one owner at a time).
// Optional performance counters are enabled by defining L2_ARB_PERF_CNT_EN.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_I_L2,
  input  logic [ADDR_W-1:0] addr_I,
  output logic              ready_L2_I,
  input  logic              read_D_L2,
  input  logic              write_D_L2,
  input  logic [ADDR_W-1:0] addr_D,
  input  logic [LINE_W-1:0] wdata_D,
  output logic              ready_L2_D,
  output logic              read_arb_L2,
  output logic              write_arb_L2,
  output logic [ADDR_W-1:0] addr_arb_L2,
  output logic [LINE_W-1:0] wdata_arb_L2,
  input  logic              ready_L2_arb,
  output logic [1:0]        owner
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       grant_cnt_I,
  output logic [31:0]       grant_cnt_D,
  output logic [31:0]       wait_cnt
`endif
);

  state_t            r_state, w_state_nxt;
  logic              r_read, w_read_nxt;
  logic              r_write, w_write_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [LINE_W-1:0] r_wdata, w_wdata_nxt;
  logic [1:0]        r_owner, w_owner_nxt;
  logic              r_last_grant, w_last_nxt;
  logic              r_rdy_i, w_rdy_i_nxt;
  logic              r_rdy_d, w_rdy_d_nxt;

  logic [1:0]        w_req;
  logic [1:0]        w_pick_grant;
  logic              w_pick_valid;

  assign w_req = {read_D_L2 | write_D_L2, read_I_L2};

  l2_arb_rr_pick u_pick (
    .req        (w_req),
    .last_grant (r_last_grant),
    .grant      (w_pick_grant),
    .valid      (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_read_nxt  = r_read;
    w_write_nxt = r_write;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_grant;
    w_rdy_i_nxt = 1'b0;
    w_rdy_d_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_pick_grant;
          w_last_nxt  = w_pick_grant[1];
          if (w_pick_grant == OWN_D) begin
            // A pending write-back goes first; the read stays pending for a later round.
            w_write_nxt = write_D_L2;
            w_read_nxt  = ~write_D_L2;
            w_addr_nxt  = addr_D;
            w_wdata_nxt = wdata_D;
          end else begin
            w_write_nxt = 1'b0;
            w_read_nxt  = 1'b1;
            w_addr_nxt  = addr_I;
            w_wdata_nxt = '0;
          end
        end
      end
      S_GRANT: begin
        if (ready_L2_arb) begin
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
          w_rdy_i_nxt = (r_owner == OWN_I);
          w_rdy_d_nxt = (r_owner == OWN_D);
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_owner_nxt = OWN_NONE;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
        w_owner_nxt = OWN_NONE;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner      <= OWN_NONE;
      r_last_grant <= 1'b1;
      r_rdy_i      <= 1'b0;
      r_rdy_d      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_read       <= w_read_nxt;
      r_write      <= w_write_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
      r_rdy_i      <= w_rdy_i_nxt;
      r_rdy_d      <= w_rdy_d_nxt;
    end
  end

  assign read_arb_L2  = r_read;
  assign write_arb_L2 = r_write;
  assign addr_arb_L2  = r_addr;
  assign wdata_arb_L2 = r_wdata;
  assign owner        = r_owner;
  assign ready_L2_I   = r_rdy_i;
  assign ready_L2_D   = r_rdy_d;

`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0] r_grant_cnt_i;
  logic [31:0] r_grant_cnt_d;
  logic [31:0] r_wait_cnt;
  logic [1:0]  w_wait_inc;
  logic [32:0] w_wait_sum;
  logic        w_granting;

  // Each side that requests while not owning adds one wait cycle.
  assign w_wait_inc = {1'b0, w_req[0] & (r_owner != OWN_I)} +
                      {1'b0, w_req[1] & (r_owner != OWN_D)};
  assign w_wait_sum = {1'b0, r_wait_cnt} + {31'b0, w_wait_inc};
  assign w_granting = (r_state == S_IDLE) && w_pick_valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_grant_cnt_i <= '0;
      r_grant_cnt_d <= '0;
      r_wait_cnt    <= '0;
    end else begin
      if (w_granting && w_pick_grant[0]) r_grant_cnt_i <= r_grant_cnt_i + 32'd1;
      if (w_granting && w_pick_grant[1]) r_grant_cnt_d <= r_grant_cnt_d + 32'd1;
      r_wait_cnt <= w_wait_sum[32] ? 32'hFFFF_FFFF : w_wait_sum[31:0];
    end
  end

  assign grant_cnt_I = r_grant_cnt_i;
  assign grant_cnt_D = r_grant_cnt_d;
  assign wait_cnt    = r_wait_cnt;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus random traffic against a cycle reference model.
module tb_l2_arbiter;

  localparam int AW = 26;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          nrst;
  logic          read_I_L2;
  logic [AW-1:0] addr_I;
  logic          ready_L2_I;
  logic          read_D_L2;
  logic          write_D_L2;
  logic [AW-1:0] addr_D;
  logic [LW-1:0] wdata_D;
  logic          ready_L2_D;
  logic          read_arb_L2;
  logic          write_arb_L2;
  logic [AW-1:0] addr_arb_L2;
  logic [LW-1:0] wdata_arb_L2;
  logic          ready_L2_arb;
  logic [1:0]    owner;
`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0]   grant_cnt_I;
  logic [31:0]   grant_cnt_D;
  logic [31:0]   wait_cnt;
`endif

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .read_I_L2    (read_I_L2),
    .addr_I       (addr_I),
    .ready_L2_I   (ready_L2_I),
    .read_D_L2    (read_D_L2),
    .write_D_L2   (write_D_L2),
    .addr_D       (addr_D),
    .wdata_D      (wdata_D),
    .ready_L2_D   (ready_L2_D),
    .read_arb_L2  (read_arb_L2),
    .write_arb_L2 (write_arb_L2),
    .addr_arb_L2  (addr_arb_L2),
    .wdata_arb_L2 (wdata_arb_L2),
    .ready_L2_arb (ready_L2_arb),
    .owner        (owner)
`ifdef L2_ARB_PERF_CNT_EN
    ,
    .grant_cnt_I  (grant_cnt_I),
    .grant_cnt_D  (grant_cnt_D),
    .wait_cnt     (wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;

  // Reference model: a transaction is either in flight, draining for one release cycle, or absent.
  bit            mBusy, mReleasing, mLastWasD, mIsWrite, mReadyI, mReadyD;
  logic [1:0]    mOwner;
  logic [AW-1:0] mAddr;
  logic [LW-1:0] mData;
`ifdef L2_ARB_PERF_CNT_EN
  longint        mWait;
`endif

  // Stimulus agents and bookkeeping of what the DUT showed.
  bit   l2Auto, randLat, spurious, randMode, iRepeat, dRepeat, iReraise, dReraise;
  int   l2Wait, fixedLat;
  int   pulsesI, pulsesD;
  logic [AW-1:0] seenAddr;
  logic [1:0]    prevOwner;
  logic [1:0]    grantLog[$];
  bit            opLog[$];
  logic [LW-1:0] dataLog[$];

  task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mReleasing = 0; mLastWasD = 1; mIsWrite = 0;
    mReadyI = 0; mReadyD = 0; mOwner = 2'b00; mAddr = '0; mData = '0;
`ifdef L2_ARB_PERF_CNT_EN
    mWait = 0;
`endif
  endtask

  task automatic modelStep();
    bit wantI, wantD, takeD;
    wantI = read_I_L2;
    wantD = read_D_L2 || write_D_L2;
`ifdef L2_ARB_PERF_CNT_EN
    if (wantI && mOwner != 2'b01) mWait++;
    if (wantD && mOwner != 2'b10) mWait++;
    if (mWait > 64'hFFFF_FFFF) mWait = 64'hFFFF_FFFF;
`endif
    mReadyI = 0;
    mReadyD = 0;
    if (mBusy) begin
      if (ready_L2_arb) begin
        mBusy = 0;
        mReleasing = 1;
        if (mOwner == 2'b01) mReadyI = 1;
        else mReadyD = 1;
      end
    end else if (mReleasing) begin
      mReleasing = 0;
      mOwner = 2'b00;
    end else if (wantI || wantD) begin
      takeD = wantD && (!wantI || !mLastWasD);
      mBusy = 1;
      mLastWasD = takeD;
      if (takeD) begin
        mOwner = 2'b10; mIsWrite = write_D_L2; mAddr = addr_D; mData = wdata_D;
      end else begin
        mOwner = 2'b01; mIsWrite = 0; mAddr = addr_I; mData = '0;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("read",   LW'(read_arb_L2),  LW'(mBusy && !mIsWrite));
    checkOutput("write",  LW'(write_arb_L2), LW'(mBusy && mIsWrite));
    checkOutput("addr",   LW'(addr_arb_L2),  LW'(mAddr));
    checkOutput("wdata",  wdata_arb_L2,      mData);
    checkOutput("owner",  LW'(owner),        LW'(mOwner));
    checkOutput("readyI", LW'(ready_L2_I),   LW'(mReadyI));
    checkOutput("readyD", LW'(ready_L2_D),   LW'(mReadyD));
`ifdef L2_ARB_PERF_CNT_EN
    checkOutput("waitCnt", LW'(wait_cnt), LW'(mWait));
`endif
  endtask

  task automatic applyStimulus();
    ready_L2_arb = 1'b0;
    if (l2Auto) begin
      if (read_arb_L2 || write_arb_L2) begin
        if (l2Wait == 0) begin
          ready_L2_arb = 1'b1;
          l2Wait = randLat ? int'($urandom_range(0, 4)) : fixedLat;
        end else l2Wait--;
      end else if (spurious && $urandom_range(0, 7) == 0) ready_L2_arb = 1'b1;
    end
    if (ready_L2_I) begin
      read_I_L2 = 1'b0;
      if (iRepeat) iReraise = 1;
    end else if (iReraise) begin
      read_I_L2 = 1'b1;
      iReraise = 0;
    end
    if (ready_L2_D) begin
      if (write_D_L2) write_D_L2 = 1'b0;
      else begin
        read_D_L2 = 1'b0;
        if (dRepeat) dReraise = 1;
      end
    end else if (dReraise) begin
      read_D_L2 = 1'b1;
      dReraise = 0;
    end
    if (randMode) begin
      if (!read_I_L2 && $urandom_range(0, 3) == 0) read_I_L2 = 1'b1;
      else if (read_I_L2 && $urandom_range(0, 15) == 0) read_I_L2 = 1'b0;
      if ($urandom_range(0, 3) == 0) addr_I = AW'($urandom);
      if (!read_D_L2 && !write_D_L2 && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: read_D_L2 = 1'b1;
          1: write_D_L2 = 1'b1;
          default: begin read_D_L2 = 1'b1; write_D_L2 = 1'b1; end
        endcase
      end else if ($urandom_range(0, 15) == 0) begin
        read_D_L2 = 1'b0; write_D_L2 = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) addr_D = AW'($urandom);
      if ($urandom_range(0, 3) == 0) wdata_D = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!nrst) modelReset();
    else modelStep();
    #1;
    checkAll();
    if (ready_L2_I) pulsesI++;
    if (ready_L2_D) pulsesD++;
    if (read_arb_L2 || write_arb_L2) seenAddr = addr_arb_L2;
    if (owner != 2'b00 && prevOwner == 2'b00) begin
      grantLog.push_back(owner);
      opLog.push_back(write_arb_L2);
      dataLog.push_back(wdata_arb_L2);
    end
    prevOwner = owner;
    applyStimulus();
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clearLogs();
    pulsesI = 0; pulsesD = 0;
    grantLog.delete(); opLog.delete(); dataLog.delete();
  endtask

  task automatic applyReset();
    #2 nrst = 1'b0;
    modelReset();
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0;
    read_I_L2 = 0; addr_I = '0; read_D_L2 = 0; write_D_L2 = 0;
    addr_D = '0; wdata_D = '0; ready_L2_arb = 0;
    l2Auto = 1; randLat = 0; spurious = 0; randMode = 0;
    iRepeat = 0; dRepeat = 0; iReraise = 0; dReraise = 0;
    fixedLat = 3; l2Wait = 3; prevOwner = 2'b00; seenAddr = '0;
    modelReset();
    clearLogs();
    #2;
    checkOutput("rstRead",  LW'(read_arb_L2),  '0);
    checkOutput("rstWrite", LW'(write_arb_L2), '0);
    checkOutput("rstOwner", LW'(owner),        '0);
    checkOutput("rstRdyI",  LW'(ready_L2_I),   '0);
    checkOutput("rstRdyD",  LW'(ready_L2_D),   '0);
    #10 nrst = 1'b1;

    $display("[TB] I-only read");
    addr_I = 26'h0000ABC;
    read_I_L2 = 1'b1;
    runTicks(12);
    checkOutput("s1PulsesI", LW'(pulsesI), LW'(1));
    checkOutput("s1PulsesD", LW'(pulsesD), LW'(0));
    checkOutput("s1Addr",    LW'(seenAddr), LW'(26'h0000ABC));
    checkOutput("s1Grants",  LW'(grantLog.size()), LW'(1));

    $display("[TB] alternation over four rounds");
    applyReset();
    clearLogs();
    fixedLat = 1; l2Wait = 1;
    iRepeat = 1; dRepeat = 1;
    addr_I = 26'h0000100; addr_D = 26'h0000200;
    read_I_L2 = 1'b1; read_D_L2 = 1'b1;
    for (int i = 0; i < 200 && grantLog.size() < 4; i++) tick();
    iRepeat = 0; dRepeat = 0; iReraise = 0; dReraise = 0;
    read_I_L2 = 1'b0;
    runTicks(10);
    checkOutput("altCount", LW'(grantLog.size()), LW'(4));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("altOrder%0d", i),
                  LW'(grantLog.size() > i ? grantLog[i] : 2'b11),
                  LW'((i % 2 == 0) ? 2'b01 : 2'b10));
`ifdef L2_ARB_PERF_CNT_EN
    checkOutput("grantCntI", LW'(grant_cnt_I), LW'(2));
    checkOutput("grantCntD", LW'(grant_cnt_D), LW'(2));
`endif

    $display("[TB] D read+write together");
    clearLogs();
    fixedLat = 2; l2Wait = 2;
    addr_D = 26'h1234567;
    wdata_D = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    read_D_L2 = 1'b1; write_D_L2 = 1'b1;
    runTicks(20);
    checkOutput("s3PulsesD", LW'(pulsesD), LW'(2));
    checkOutput("s3Grants",  LW'(grantLog.size()), LW'(2));
    checkOutput("s3FirstOp", LW'(opLog.size() > 0 ? opLog[0] : 1'b0), LW'(1));
    checkOutput("s3SecondOp", LW'(opLog.size() > 1 ? opLog[1] : 1'b1), LW'(0));
    checkOutput("s3Data", dataLog.size() > 0 ? dataLog[0] : '0,
                128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    checkOutput("s3Addr", LW'(seenAddr), LW'(26'h1234567));

    $display("[TB] request dropped during grant");
    clearLogs();
    addr_I = 26'h2AAAAAA;
    read_I_L2 = 1'b1;
    tick();
    read_I_L2 = 1'b0;
    addr_I = 26'h0155555;
    runTicks(10);
    checkOutput("s4PulsesI", LW'(pulsesI), LW'(1));
    checkOutput("s4Addr",    LW'(seenAddr), LW'(26'h2AAAAAA));

    $display("[TB] spurious L2 ready while idle");
    clearLogs();
    l2Auto = 0;
    ready_L2_arb = 1'b1;
    runTicks(3);
    ready_L2_arb = 1'b0;
    checkOutput("s5PulsesI", LW'(pulsesI), LW'(0));
    checkOutput("s5PulsesD", LW'(pulsesD), LW'(0));

    $display("[TB] reset during grant");
    addr_D = 26'h0ABCDEF;
    read_D_L2 = 1'b1;
    runTicks(2);
    #2 nrst = 1'b0;
    #1;
    checkOutput("midRstRead",  LW'(read_arb_L2),  '0);
    checkOutput("midRstWrite", LW'(write_arb_L2), '0);
    checkOutput("midRstOwner", LW'(owner),        '0);
    checkOutput("midRstRdyI",  LW'(ready_L2_I),   '0);
    checkOutput("midRstRdyD",  LW'(ready_L2_D),   '0);
    modelReset();
    read_D_L2 = 1'b0;
    tick();
    nrst = 1'b1;
    runTicks(3);

    $display("[TB] random traffic");
    l2Auto = 1; randLat = 1; spurious = 1; randMode = 1; l2Wait = 0;
    runTicks(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
